alu_seq_ctrl: RTL and testbench

//  Sequencer in front of the EX-stage ALU. Accepts one operation (4-bit ALU control code + operands) per handshake.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_mul.sv | 60 ++++++
 rtl/alu_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and sequencer state encoding
// Purpose: 4-bit ALU control codes used by the decoder and the EX-stage
// sequencer, plus the sequencer FSM state type. No ports.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier step datapath
// Purpose: one multiplier bit per step; low WIDTH bits of a*b after WIDTH steps.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            load a/b, clear accumulator and iteration counter
//   a, b             multiplicand / multiplier loaded on start
//   step             perform one shift-add iteration
//   clr              clear the iteration counter (operation retired)
//   prod_next        accumulator value after the current step
//   done             current step is the last one (count == WIDTH-1)
module alu_seq_mul #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    input  logic             clr,
    output logic [WIDTH-1:0] prod_next,
    output logic             done
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    // Product bits above WIDTH are never needed, so the multiplicand simply
    // shifts left inside WIDTH bits and its high bits fall off.
    assign prod_next = acc + (mplier[0] ? mcand : '0);
    assign done      = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
        end else if (step) begin
            acc    <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            // Saturate at the last iteration; only clr/start bring it back.
            if (!done) begin
                cnt <= cnt + 1'b1;
            end
        end else if (clr) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - EX-stage ALU sequencer: handshake, FSM, ALU mux, result register
// Purpose: accepts one op per in_valid/in_ready handshake, runs single-cycle
// ops through EXEC and MUL as a WIDTH-step shift-add, holds the result in DONE
// until out_ready. Build macro ALU_SEQ_MUL_EN enables MUL; without it 1111 is
// decoded as an unknown op and the multiplier is not built.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid, in_ready     request handshake (in_ready only in IDLE)
//   op, a, b, shamt        ALU control code, operands, shift amount
//   out_valid, out_ready   result handshake (out_valid only in DONE)
//   result, zero, illegal  registered result and flags
//   busy                   state != IDLE
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    state_t           state;
    state_t           state_n;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [4:0]       shamt_q;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    logic             accept;
    logic             retire;
    logic             is_mul;

    assign accept = (state == ST_IDLE) && in_valid;
    assign retire = (state == ST_DONE) && out_ready;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mul_prod;
    logic             mul_done;

    assign is_mul = (op == OP_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start     (accept && is_mul),
        .a         (a),
        .b         (b),
        .step      (state == ST_MUL),
        .clr       (retire),
        .prod_next (mul_prod),
        .done      (mul_done)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_n = is_mul ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: state_n = ST_DONE;
            ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                if (mul_done) begin
                    state_n = ST_DONE;
                end
`else
                state_n = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Single-cycle ALU. MUL never reaches EXEC when the multiplier is built,
    // so 1111 falls into the unknown-code default either way.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_ADD:  alu_res = a_q + b_q;
            OP_SLL:  alu_res = b_q << shamt_q;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_SUB:  alu_res = a_q - b_q;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SRL:  alu_res = b_q >> shamt_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            shamt_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op;
                a_q     <= a;
                b_q     <= b;
                shamt_q <= shamt;
            end
            if (state == ST_EXEC) begin
                result_q  <= alu_res;
                zero_q    <= (alu_res == '0);
                illegal_q <= alu_ill;
            end
`ifdef ALU_SEQ_MUL_EN
            if ((state == ST_MUL) && mul_done) begin
                result_q  <= mul_prod;
                zero_q    <= (mul_prod == '0);
                illegal_q <= 1'b0;
            end
`endif
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

    localparam int W = 32;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] result;
        logic         zero;
        logic         illegal;
        int           lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] result;
        logic         zero;
        logic         illegal;
        int           lat;
        int           bad_wait;
        int           bad_hold;
        logic         ready_after;
        logic         valid_after;
    } obs_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [4:0]   shamt = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;
    logic         busy;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic [4:0] s);
        exp_t e;
        logic [2*W-1:0] full;
        e.result  = '0;
        e.illegal = 1'b0;
        e.lat     = 2;
        case (o)
            4'b0000: e.result = x & y;
            4'b0001: e.result = x | y;
            4'b0010: e.result = x + y;
            4'b0011: e.result = y << s;
            4'b0100: e.result = (x < y) ? 1 : 0;
            4'b0110: e.result = x - y;
            4'b0111: e.result = ($signed(x) < $signed(y)) ? 1 : 0;
            4'b1011: e.result = y >> s;
            4'b1100: e.result = ~(x | y);
            4'b1111: begin
                if (MUL_EN) begin
                    full     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                    e.result = full[W-1:0];
                    e.lat    = W + 1;
                end else begin
                    e.illegal = 1'b1;
                end
            end
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    task automatic send(input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [4:0] s);
        op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
        sb.push_back(model(o, x, y, s));
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = $urandom; a = $urandom; b = $urandom; shamt = $urandom;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [4:0] s,
                          input int hold, output exp_t e, output obs_t r);
        logic [W-1:0] held;
        send(o, x, y, s);
        r.lat = 1;
        r.bad_wait = 0;
        r.bad_hold = 0;
        while (out_valid !== 1'b1 && r.lat < 200) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) r.bad_wait++;
            @(posedge clk); #1;
            r.lat++;
        end
        r.result  = result;
        r.zero    = zero;
        r.illegal = illegal;
        held      = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) r.bad_hold++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        r.ready_after = in_ready;
        r.valid_after = out_valid;
        e = sb.pop_front();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_total++;
        if ({in_ready, out_valid, busy, zero, illegal} !== 5'b10000 || result !== '0)
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b z=%b ill=%b res=%h, want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, zero, illegal, result);
        else n_pass++;
    endtask

    task automatic test_single_cycle;
        exp_t e; obs_t r;
        run_op(4'b0010, 7, 5, 0, 0, e, r);
        n_total++;
        if (r.result !== 32'd12 || r.result !== e.result) $display("FAIL add_result: got %h want %h", r.result, e.result);
        else n_pass++;
        n_total++;
        if (r.zero !== 1'b0 || r.illegal !== 1'b0) $display("FAIL add_flags: got z=%b ill=%b want 0 0", r.zero, r.illegal);
        else n_pass++;
        n_total++;
        if (r.lat !== 2) $display("FAIL add_latency: got %0d want 2", r.lat);
        else n_pass++;
        n_total++;
        if (r.bad_wait !== 0 || r.ready_after !== 1'b1 || r.valid_after !== 1'b0)
            $display("FAIL add_handshake: got bad=%0d rdy=%b vld=%b want 0 1 0", r.bad_wait, r.ready_after, r.valid_after);
        else n_pass++;
    endtask

    task automatic test_compare;
        exp_t e; obs_t r;
        run_op(4'b0111, 32'hFFFF_FFFF, 1, 0, 0, e, r);
        n_total++;
        if (r.result !== e.result || r.result !== 32'd1) $display("FAIL slt_result: got %h want %h", r.result, e.result);
        else n_pass++;
        run_op(4'b0100, 32'hFFFF_FFFF, 1, 0, 0, e, r);
        n_total++;
        if (r.result !== e.result || r.zero !== 1'b1) $display("FAIL sltu_result: got %h z=%b want %h z=1", r.result, r.zero, e.result);
        else n_pass++;
    endtask

    task automatic test_alu_ops;
        logic [3:0] codes [6];
        exp_t e; obs_t r;
        codes = '{4'b0000, 4'b0001, 4'b0011, 4'b1011, 4'b1100, 4'b0110};
        for (int i = 0; i < 12; i++) begin
            logic [3:0] o;
            logic [W-1:0] x, y;
            logic [4:0] s;
            o = codes[i % 6];
            x = $urandom; y = $urandom; s = $urandom;
            if (i == 6) s = 5'd31;
            if (i == 7) s = 5'd0;
            run_op(o, x, y, s, 0, e, r);
            n_total++;
            if (r.result !== e.result || r.zero !== e.zero || r.illegal !== e.illegal || r.lat !== e.lat)
                $display("FAIL alu_op_%0d op=%b: got %h z=%b ill=%b lat=%0d want %h z=%b ill=%b lat=%0d",
                         i, o, r.result, r.zero, r.illegal, r.lat, e.result, e.zero, e.illegal, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_multiply;
        exp_t e; obs_t r;
        run_op(4'b1111, 32'h1234, 32'h10, 0, 0, e, r);
        n_total++;
        if (r.result !== e.result || r.illegal !== e.illegal) $display("FAIL mul_result: got %h ill=%b want %h ill=%b", r.result, r.illegal, e.result, e.illegal);
        else n_pass++;
        n_total++;
        if (r.lat !== e.lat) $display("FAIL mul_latency: got %0d want %0d", r.lat, e.lat);
        else n_pass++;
        n_total++;
        if (r.bad_wait !== 0) $display("FAIL mul_busy: got %0d bad cycles want 0", r.bad_wait);
        else n_pass++;
        run_op(4'b1111, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 0, e, r);
        n_total++;
        if (r.result !== e.result || r.zero !== e.zero || r.lat !== e.lat)
            $display("FAIL mul_wrap: got %h z=%b lat=%0d want %h z=%b lat=%0d", r.result, r.zero, r.lat, e.result, e.zero, e.lat);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        exp_t e; obs_t r;
        run_op(4'b0010, 100, 23, 0, 5, e, r);
        n_total++;
        if (r.bad_hold !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", r.bad_hold);
        else n_pass++;
        n_total++;
        if (r.result !== e.result) $display("FAIL bp_result: got %h want %h", r.result, e.result);
        else n_pass++;
        n_total++;
        if (r.ready_after !== 1'b1 || r.valid_after !== 1'b0) $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", r.ready_after, r.valid_after);
        else n_pass++;
    endtask

    task automatic test_unknown_and_zero;
        exp_t e; obs_t r;
        run_op(4'b1010, 32'h55, 32'hAA, 3, 0, e, r);
        n_total++;
        if (r.illegal !== 1'b1 || r.result !== '0 || r.zero !== 1'b1 || r.lat !== e.lat)
            $display("FAIL unknown_op: got res=%h z=%b ill=%b lat=%0d want 0 1 1 %0d", r.result, r.zero, r.illegal, r.lat, e.lat);
        else n_pass++;
        run_op(4'b0110, 9, 9, 0, 0, e, r);
        n_total++;
        if (r.zero !== 1'b1 || r.illegal !== 1'b0 || r.result !== e.result)
            $display("FAIL sub_zero: got res=%h z=%b ill=%b want %h 1 0", r.result, r.zero, r.illegal, e.result);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op;
        exp_t e; obs_t r;
        logic seen;
        seen = 1'b0;
        send(4'b1111, 32'h0F0F_0F0F, 32'h1357_9BDF, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_total++;
        if (seen !== (e.lat <= 10)) $display("FAIL abort_valid_seen: got %b want %b", seen, (e.lat <= 10));
        else n_pass++;
        n_total++;
        if ({in_ready, out_valid, busy, zero, illegal} !== 5'b10000 || result !== '0)
            $display("FAIL abort_state: got rdy=%b vld=%b busy=%b z=%b ill=%b res=%h want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, zero, illegal, result);
        else n_pass++;
        run_op(4'b0010, 32'h8000_0000, 32'h8000_0000, 0, 0, e, r);
        n_total++;
        if (r.result !== e.result || r.zero !== 1'b1 || r.lat !== 2)
            $display("FAIL post_abort_add: got %h z=%b lat=%0d want %h 1 2", r.result, r.zero, r.lat, e.result);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        exp_t e; obs_t r;
        int bad;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] o;
            o = (i % 3 == 0) ? 4'b0010 : ((i % 3 == 1) ? 4'b1111 : 4'b0111);
            run_op(o, $urandom, $urandom, $urandom, i % 2, e, r);
            if (r.result !== e.result || r.zero !== e.zero || r.illegal !== e.illegal ||
                r.lat !== e.lat || r.ready_after !== 1'b1) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL back_to_back: got %0d bad ops want 0", bad);
        else n_pass++;
        n_total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_compare();
        test_alu_ops();
        test_multiply();
        test_backpressure();
        test_unknown_and_zero();
        test_reset_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
